// File: rtl/synth_pkg.sv
// Shared definitions for the polyphonic wavetable synth:
// FSM encodings, waveform codes and small sizing helpers.
package synth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_MAC,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        WAVE_SIN      = 3'd0,
        WAVE_TRUMPET  = 3'd1,
        WAVE_VIOLIN   = 3'd2,
        WAVE_CLARINET = 3'd3,
        WAVE_ORGAN    = 3'd4
    } wave_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Offset-binary midpoint (zero level) for a w-bit sample.
    function automatic int out_mid(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/synth_voice_cfg_regs.sv
// Per-voice config register file: live registers written at any time,
// plus a working copy captured when a frame starts.
module synth_voice_cfg_regs
    import synth_pkg::*;
#(
    parameter int NVOICE  = 4,
    parameter int PHASE_W = 24,
    parameter int WAVE_W  = 3,
    parameter int VOL_W   = 8
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic                             cfg_we,
    input  logic [3:0]                       cfg_voice,
    input  logic [PHASE_W-1:0]               cfg_fcw,
    input  logic [WAVE_W-1:0]                cfg_wave,
    input  logic [VOL_W-1:0]                 cfg_vol,
    input  logic                             cfg_en,
    input  logic                             snap,
    output logic [NVOICE-1:0][PHASE_W-1:0]   fcw,
    output logic [NVOICE-1:0][WAVE_W-1:0]    wave,
    output logic [NVOICE-1:0][VOL_W-1:0]     vol,
    output logic [NVOICE-1:0]                en
);

    logic [NVOICE-1:0][PHASE_W-1:0] live_fcw;
    logic [NVOICE-1:0][WAVE_W-1:0]  live_wave;
    logic [NVOICE-1:0][VOL_W-1:0]   live_vol;
    logic [NVOICE-1:0]              live_en;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            live_fcw  <= '0;
            live_wave <= '0;
            live_vol  <= '0;
            live_en   <= '0;
            fcw       <= '0;
            wave      <= '0;
            vol       <= '0;
            en        <= '0;
        end else begin
            // Out-of-range voice indices match no entry and are dropped.
            for (int i = 0; i < NVOICE; i++) begin
                if (cfg_we && int'(cfg_voice) == i) begin
                    live_fcw[i]  <= cfg_fcw;
                    live_wave[i] <= cfg_wave;
                    live_vol[i]  <= cfg_vol;
                    live_en[i]   <= cfg_en;
                end
            end
            if (snap) begin
                fcw  <= live_fcw;
                wave <= live_wave;
                vol  <= live_vol;
                en   <= live_en;
            end
        end
    end

endmodule

// File: rtl/dds_poly_wavetable_engine.sv
// Polyphonic DDS wavetable engine: voices share one ROM, are scaled,
// summed and saturated into one offset-binary sample per frame.
module dds_poly_wavetable_engine
    import synth_pkg::*;
#(
    parameter int NVOICE  = 4,
    parameter int PHASE_W = 24,
    parameter int ADDR_W  = 9,
    parameter int WAVE_W  = 3,
    parameter int DATA_W  = 16,
    parameter int VOL_W   = 8,
    parameter int OUT_W   = 10
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     sample_tick,
    input  logic                     cfg_we,
    input  logic [3:0]               cfg_voice,
    input  logic [PHASE_W-1:0]       cfg_fcw,
    input  logic [WAVE_W-1:0]        cfg_wave,
    input  logic [VOL_W-1:0]         cfg_vol,
    input  logic                     cfg_en,
    output logic [WAVE_W+ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic [OUT_W-1:0]         sample_out,
    output logic                     sample_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int VIDX_W = (NVOICE > 1) ? clog2(NVOICE) : 1;
    localparam int PROD_W = DATA_W + VOL_W + 1;
    localparam int ACC_W  = PROD_W + clog2(NVOICE);
    localparam int SHIFT  = DATA_W + VOL_W - OUT_W;

    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(out_mid(OUT_W) - 1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -ACC_W'(out_mid(OUT_W));
    localparam logic [OUT_W-1:0] MID = OUT_W'(out_mid(OUT_W));

    state_t state_q;
    state_t state_d;

    logic [VIDX_W-1:0]              voice;
    logic signed [ACC_W-1:0]        acc;
    logic [NVOICE-1:0][PHASE_W-1:0] phase;

    logic [NVOICE-1:0][PHASE_W-1:0] fcw_s;
    logic [NVOICE-1:0][WAVE_W-1:0]  wave_s;
    logic [NVOICE-1:0][VOL_W-1:0]   vol_s;
    logic [NVOICE-1:0]              en_s;

    logic                     accept;
    logic                     last;
    logic signed [DATA_W-1:0] samp;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  y;
    logic [OUT_W-1:0]         y_sat;

    assign accept = (state_q == ST_IDLE) && sample_tick;
    assign last   = (voice == VIDX_W'(NVOICE - 1));

    synth_voice_cfg_regs #(
        .NVOICE  (NVOICE),
        .PHASE_W (PHASE_W),
        .WAVE_W  (WAVE_W),
        .VOL_W   (VOL_W)
    ) u_cfg (
        .CLK       (CLK),
        .nRST      (nRST),
        .cfg_we    (cfg_we),
        .cfg_voice (cfg_voice),
        .cfg_fcw   (cfg_fcw),
        .cfg_wave  (cfg_wave),
        .cfg_vol   (cfg_vol),
        .cfg_en    (cfg_en),
        .snap      (accept),
        .fcw       (fcw_s),
        .wave      (wave_s),
        .vol       (vol_s),
        .en        (en_s)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (sample_tick) state_d = ST_ADDR;
            ST_ADDR: state_d = ST_WAIT;
            ST_WAIT: state_d = ST_MAC;
            ST_MAC:  state_d = last ? ST_DONE : ST_ADDR;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ROM word is offset-binary; flipping the MSB gives two's complement.
    always_comb begin
        samp = {~rom_data[DATA_W-1], rom_data[DATA_W-2:0]};
        prod = PROD_W'(samp) * PROD_W'($signed({1'b0, vol_s[voice]}));
    end

    always_comb begin
        y = acc >>> SHIFT;
        if (y > Y_MAX) begin
            y_sat = Y_MAX[OUT_W-1:0];
        end else if (y < Y_MIN) begin
            y_sat = Y_MIN[OUT_W-1:0];
        end else begin
            y_sat = y[OUT_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            voice        <= '0;
            acc          <= '0;
            phase        <= '0;
            rom_addr     <= '0;
            sample_out   <= MID;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            overrun      <= sample_tick && (state_q != ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    if (sample_tick) begin
                        acc   <= '0;
                        busy  <= 1'b1;
                        voice <= '0;
                    end
                end
                ST_ADDR: begin
                    rom_addr <= {wave_s[voice],
                                 phase[voice][PHASE_W-1 -: ADDR_W]};
                end
                ST_WAIT: begin
                end
                ST_MAC: begin
                    if (en_s[voice]) begin
                        acc          <= acc + ACC_W'(prod);
                        phase[voice] <= phase[voice] + fcw_s[voice];
                    end else begin
                        phase[voice] <= '0;
                    end
                    voice <= voice + VIDX_W'(1);
                end
                ST_DONE: begin
                    sample_out   <= {~y_sat[OUT_W-1], y_sat[OUT_W-2:0]};
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_poly_wavetable_engine.sv
// Self-checking bench: constant-ROM vector table, hand-written corner
// sequences and randomized frames against an arithmetic reference model.
module tb_dds_poly_wavetable_engine;

    logic        CLK;
    logic        nRST;
    logic        sample_tick;
    logic        cfg_we;
    logic [3:0]  cfg_voice;
    logic [23:0] cfg_fcw;
    logic [2:0]  cfg_wave;
    logic [7:0]  cfg_vol;
    logic        cfg_en;
    logic [11:0] rom_addr;
    logic [15:0] rom_data;
    logic [9:0]  sample_out;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    int total;
    int passed;

    logic [15:0] rom_mem [0:4095];

    int     m_fcw   [4];
    int     m_wave  [4];
    int     m_vol   [4];
    bit     m_en    [4];
    longint m_phase [4];

    typedef struct {
        logic [15:0] rom;
        logic [3:0]  en;
        logic [7:0]  vol;
        logic [9:0]  exp;
    } vec_t;

    vec_t tbl [8];

    dds_poly_wavetable_engine dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .sample_tick  (sample_tick),
        .cfg_we       (cfg_we),
        .cfg_voice    (cfg_voice),
        .cfg_fcw      (cfg_fcw),
        .cfg_wave     (cfg_wave),
        .cfg_vol      (cfg_vol),
        .cfg_en       (cfg_en),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) rom_data <= rom_mem[rom_addr];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int v = 0; v < 4; v++) begin
            m_fcw[v] = 0;
            m_wave[v] = 0;
            m_vol[v] = 0;
            m_en[v] = 1'b0;
            m_phase[v] = 0;
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        step();
        step();
        nRST = 1'b1;
        model_clear();
    endtask

    task automatic rom_fill(input logic [15:0] val);
        for (int i = 0; i < 4096; i++) rom_mem[i] = val;
    endtask

    task automatic wr(input int v, input int fcw, input int wave,
                      input int vol, input bit en);
        cfg_voice = 4'(v);
        cfg_fcw = 24'(fcw);
        cfg_wave = 3'(wave);
        cfg_vol = 8'(vol);
        cfg_en = en;
        cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        if (v < 4) begin
            m_fcw[v] = fcw;
            m_wave[v] = wave;
            m_vol[v] = vol;
            m_en[v] = en;
        end
    endtask

    // lat counts edges from the tick-accepting edge to the valid cycle.
    task automatic run_frame(output int lat, output logic [9:0] s,
                             output logic [11:0] a);
        int n;
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        n = 1;
        a = rom_addr;
        while (!sample_valid && n < 40) begin
            step();
            n++;
        end
        lat = n;
        s = sample_out;
    endtask

    // One frame of the mixer from first principles: signed sum, floor
    // divide by 2^14, clamp, re-bias. Phases advance after being read.
    function automatic int model_frame();
        longint acc;
        longint y;
        int idx;
        acc = 0;
        for (int v = 0; v < 4; v++) begin
            if (m_en[v]) begin
                idx = int'(m_phase[v] / 32768);
                acc += (longint'(rom_mem[m_wave[v] * 512 + idx]) - 32768)
                       * longint'(m_vol[v]);
                m_phase[v] = (m_phase[v] + longint'(m_fcw[v])) % 16777216;
            end else begin
                m_phase[v] = 0;
            end
        end
        y = acc >>> 14;
        if (y > 511) y = 511;
        if (y < -512) y = -512;
        return int'(y + 512);
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nv;
        int exp_s;
        int exp_a;
        logic [9:0]  s;
        logic [11:0] a;
        logic [9:0]  sn;
        int idx_exp [4];

        total = 0;
        passed = 0;
        cfg_voice = '0;
        cfg_fcw = '0;
        cfg_wave = '0;
        cfg_vol = '0;
        cfg_en = 1'b0;
        rom_fill(16'h0000);

        tbl[0] = '{16'hFFFF, 4'b0001, 8'd255, 10'h3FD};
        tbl[1] = '{16'hFFFF, 4'b1111, 8'd255, 10'h3FF};
        tbl[2] = '{16'h0000, 4'b1111, 8'd255, 10'h000};
        tbl[3] = '{16'h0000, 4'b0000, 8'd255, 10'h200};
        tbl[4] = '{16'h0000, 4'b0001, 8'd255, 10'h002};
        tbl[5] = '{16'h8000, 4'b1111, 8'd255, 10'h200};
        tbl[6] = '{16'hC000, 4'b0001, 8'd128, 10'h280};
        tbl[7] = '{16'h4000, 4'b0011, 8'd128, 10'h100};

        // Reset state, sampled while nRST is still held low.
        nRST = 1'b0;
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        step();
        step();
        chk("reset_sample_out", 32'(sample_out), 32'h200);
        chk("reset_valid", 32'(sample_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_rom_addr", 32'(rom_addr), 0);
        chk("reset_overrun", 32'(overrun), 0);
        nRST = 1'b1;
        model_clear();

        for (int t = 0; t < 8; t++) begin
            rom_fill(tbl[t].rom);
            for (int v = 0; v < 4; v++) begin
                wr(v, 0, 0, int'(tbl[t].vol), tbl[t].en[v]);
            end
            run_frame(lat, s, a);
            chk($sformatf("tbl%0d_latency", t), 32'(lat), 13);
            chk($sformatf("tbl%0d_sample", t), 32'(s), 32'(tbl[t].exp));
            step();
            chk($sformatf("tbl%0d_busy_done", t), 32'(busy), 0);
            chk($sformatf("tbl%0d_hold", t), 32'(sample_out), 32'(tbl[t].exp));
        end

        // Phase walk of a 440 Hz voice at 125 kHz.
        do_reset();
        rom_fill(16'h8000);
        wr(0, 59056, 2, 255, 1'b1);
        idx_exp[0] = 0;
        idx_exp[1] = 1;
        idx_exp[2] = 3;
        idx_exp[3] = 5;
        for (int f = 0; f < 4; f++) begin
            run_frame(lat, s, a);
            chk($sformatf("phase_idx_f%0d", f), 32'(a[8:0]), 32'(idx_exp[f]));
            chk($sformatf("phase_wave_f%0d", f), 32'(a[11:9]), 2);
        end
        wr(0, 59056, 2, 255, 1'b0);
        run_frame(lat, s, a);
        wr(0, 59056, 2, 255, 1'b1);
        run_frame(lat, s, a);
        chk("phase_reenable_idx", 32'(a[8:0]), 0);

        // Tick while busy.
        do_reset();
        rom_fill(16'hFFFF);
        wr(0, 0, 0, 255, 1'b1);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        step();
        sample_tick = 1'b1;
        step();
        chk("overrun_pulse", 32'(overrun), 1);
        sample_tick = 1'b0;
        step();
        chk("overrun_clear", 32'(overrun), 0);
        nv = 0;
        sn = '0;
        for (int i = 0; i < 30; i++) begin
            if (sample_valid) begin
                nv++;
                sn = sample_out;
            end
            step();
        end
        chk("overrun_one_valid", 32'(nv), 1);
        chk("overrun_sample", 32'(sn), 32'h3FD);

        // Volume write mid-frame lands in the following frame.
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        wr(0, 0, 0, 128, 1'b1);
        nv = 0;
        while (!sample_valid && nv < 40) begin
            step();
            nv++;
        end
        chk("midvol_valid", 32'(sample_valid), 1);
        chk("midvol_old_vol", 32'(sample_out), 32'h3FD);
        run_frame(lat, s, a);
        chk("midvol_new_vol", 32'(s), 32'h2FF);

        // Writes to nonexistent voices must not alias onto real ones.
        for (int v = 0; v < 4; v++) wr(v, 0, 0, 255, 1'b0);
        wr(7, 0, 0, 255, 1'b1);
        wr(5, 0, 0, 255, 1'b1);
        run_frame(lat, s, a);
        chk("bad_voice_ignored", 32'(s), 32'h200);

        // Reset landing on a MAC edge aborts the frame.
        wr(0, 0, 0, 255, 1'b1);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        model_clear();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sample_out", 32'(sample_out), 32'h200);
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            if (sample_valid) nv++;
            step();
        end
        chk("abort_no_valid", 32'(nv), 0);
        run_frame(lat, s, a);
        chk("abort_cfg_cleared", 32'(s), 32'h200);

        // Randomized frames against the reference model.
        do_reset();
        for (int i = 0; i < 4096; i++) rom_mem[i] = 16'($urandom);
        for (int f = 0; f < 30; f++) begin
            nv = $urandom_range(0, 3);
            for (int w = 0; w < nv; w++) begin
                wr($urandom_range(0, 7), int'($urandom & 32'hFFFFFF),
                   $urandom_range(0, 4), $urandom_range(0, 255),
                   ($urandom_range(0, 3) != 0));
            end
            exp_a = m_wave[0] * 512 + int'(m_phase[0] / 32768);
            exp_s = model_frame();
            run_frame(lat, s, a);
            chk($sformatf("rnd%0d_latency", f), 32'(lat), 13);
            chk($sformatf("rnd%0d_addr", f), 32'(a), 32'(exp_a));
            chk($sformatf("rnd%0d_sample", f), 32'(s), 32'(exp_s));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
